// File: rtl/iexecute.sv
// RV32I execute stage: operand forwarding, ALU, branch resolution and the EX/MEM register.
// Define IEXEC_MUL_EN to add the iterative shift-add multiplier (ALUControlE 110).
module iexecute #(
  parameter int XLEN    = 32,
  parameter int RD_W    = 6,
  parameter int MUL_CYC = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] ImmExtE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [RD_W-1:0] RdE,
  input  logic [1:0]      ResultSrcE,
  input  logic            MemWriteE,
  input  logic            RegWriteE,
  input  logic            JumpE,
  input  logic            BranchE,
  input  logic            ALUSrcE,
  input  logic [2:0]      ALUControlE,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            BusyE,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [RD_W-1:0] RdM,
  output logic [1:0]      ResultSrcM,
  output logic            MemWriteM,
  output logic            RegWriteM
);

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] write_data;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] result_e;
  logic            zero_e;

  always_comb begin
    case (ForwardAE)
      2'b10:   src_a = ALUResultM;
      2'b01:   src_a = ResultW;
      default: src_a = RD1E;
    endcase
    case (ForwardBE)
      2'b10:   write_data = ALUResultM;
      2'b01:   write_data = ResultW;
      default: write_data = RD2E;
    endcase
    src_b = ALUSrcE ? ImmExtE : write_data;
  end

  // Multiply is never computed here; code 110 reads 0 in the single-cycle path.
  always_comb begin
    case (ALUControlE)
      3'b000:  alu_result = src_a + src_b;
      3'b001:  alu_result = src_a - src_b;
      3'b010:  alu_result = src_a & src_b;
      3'b011:  alu_result = src_a | src_b;
      3'b101:  alu_result = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      default: alu_result = '0;
    endcase
  end

  assign zero_e    = (alu_result == '0);
  assign PCSrcE    = JumpE | (BranchE & zero_e);
  assign PCTargetE = PCE + ImmExtE;

`ifdef IEXEC_MUL_EN
  // state | meaning
  // IDLE  | single-cycle ops; a 110 in E latches operands and starts MUL
  // MUL   | one shift-add step per cycle; last step writes the product to EX/MEM
  typedef enum logic {S_IDLE, S_MUL} state_t;

  localparam int CNT_W = $clog2(MUL_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYC - 1);

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] mul_a;
  logic [XLEN-1:0] mul_b;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] mul_product;
  logic            mul_start;
  logic            mul_last;

  assign mul_start   = (state == S_IDLE) && (ALUControlE == 3'b110);
  assign mul_last    = (state == S_MUL) && (cnt == CNT_LAST);
  assign mul_product = acc + (mul_b[0] ? mul_a : '0);
  // Busy is combinational so the mul itself is held in E until its final step.
  assign BusyE       = mul_start || ((state == S_MUL) && (cnt != CNT_LAST));
  assign result_e    = mul_last ? mul_product : alu_result;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      mul_a <= '0;
      mul_b <= '0;
      acc   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mul_start) begin
            mul_a <= src_a;
            mul_b <= src_b;
            acc   <= '0;
            cnt   <= '0;
            state <= S_MUL;
          end
        end
        S_MUL: begin
          acc   <= mul_product;
          mul_a <= mul_a << 1;
          mul_b <= mul_b >> 1;
          cnt   <= cnt + 1'b1;
          if (mul_last) begin
            cnt   <= '0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`else
  assign BusyE    = 1'b0;
  assign result_e = alu_result;
`endif

  always_ff @(posedge clk) begin
    if (reset || BusyE) begin
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
      RdM        <= '0;
      ResultSrcM <= 2'b00;
      MemWriteM  <= 1'b0;
      RegWriteM  <= 1'b0;
    end else begin
      ALUResultM <= result_e;
      WriteDataM <= write_data;
      PCPlus4M   <= PCPlus4E;
      RdM        <= RdE;
      ResultSrcM <= ResultSrcE;
      MemWriteM  <= MemWriteE;
      RegWriteM  <= RegWriteE;
    end
  end

endmodule
